// File: rtl/ex_stage_pkg.sv
// Shared datapath widths, opcode encodings and pipeline register layouts
// for the 16-bit core (used by fetch, decode and execute).
package ex_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ADD_B = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    FUNCT_ADD = 3'b000,
    FUNCT_SUB = 3'b001,
    FUNCT_AND = 3'b010,
    FUNCT_OR  = 3'b011,
    FUNCT_SLT = 3'b100
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctl_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc_plus_two;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] immediate;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  funct;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic [1:0]        alu_op;
  } idex_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
  } exmem_t;

  // Unlisted funct codes and ALUOp 11 both fall back to add.
  function automatic alu_ctl_e alu_decode(input logic [1:0] alu_op, input logic [2:0] funct);
    alu_ctl_e ctl;
    ctl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB: ctl = ALU_SUB;
          FUNCT_AND: ctl = ALU_AND;
          FUNCT_OR:  ctl = ALU_OR;
          FUNCT_SLT: ctl = ALU_SLT;
          default:   ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/ex_stage_alu16.sv
// Combinational 16-bit ALU; arithmetic wraps, no overflow flag.
module alu16
  import ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_ctl_e          op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = a + b;
    case (op)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, ALU, branch resolution and EX/MEM register.
// A taken branch squashes the instruction being loaded behind it.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [DATA_W-1:0] pc_plus_two,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] immediate,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  funct,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic [1:0]        ALUOp,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              flush,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [REG_W-1:0]  mem_write_reg,
  output logic              mem_RegWrite,
  output logic              mem_MemtoReg,
  output logic              mem_MemRead,
  output logic              mem_MemWrite
);

  idex_t             idex_q, idex_d;
  exmem_t            exmem_q, exmem_d;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  alu_ctl_e          alu_ctl;

  assign alu_b   = idex_q.alu_src ? idex_q.immediate : idex_q.read_data_2;
  assign alu_ctl = alu_decode(idex_q.alu_op, idex_q.funct);

  alu16 u_alu (
    .a      (idex_q.read_data_1),
    .b      (alu_b),
    .op     (alu_ctl),
    .result (alu_result)
  );

  assign pc_src        = idex_q.branch && (alu_result == '0);
  assign flush         = pc_src;
  assign branch_target = idex_q.pc_plus_two + {idex_q.immediate[DATA_W-2:0], 1'b0};

  // Flush and stall share one bubble encoding: the whole record zeroed.
  always_comb begin
    idex_d = '0;
    if (!(pc_src || stall)) begin
      idex_d.pc_plus_two = pc_plus_two;
      idex_d.read_data_1 = read_data_1;
      idex_d.read_data_2 = read_data_2;
      idex_d.immediate   = immediate;
      idex_d.rt          = rt;
      idex_d.rd          = rd;
      idex_d.funct       = funct;
      idex_d.reg_dst     = RegDst;
      idex_d.alu_src     = ALUSrc;
      idex_d.mem_to_reg  = MemtoReg;
      idex_d.reg_write   = RegWrite;
      idex_d.mem_read    = MemRead;
      idex_d.mem_write   = MemWrite;
      idex_d.branch      = Branch;
      idex_d.alu_op      = ALUOp;
    end
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.alu_result = alu_result;
    exmem_d.write_data = idex_q.read_data_2;
    exmem_d.write_reg  = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign mem_alu_result = exmem_q.alu_result;
  assign mem_write_data = exmem_q.write_data;
  assign mem_write_reg  = exmem_q.write_reg;
  assign mem_RegWrite   = exmem_q.reg_write;
  assign mem_MemtoReg   = exmem_q.mem_to_reg;
  assign mem_MemRead    = exmem_q.mem_read;
  assign mem_MemWrite   = exmem_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus random traffic, all checked
// against an instruction-level model of the two pipeline slots.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [15:0] pc_plus_two, read_data_1, read_data_2, immediate;
  logic [2:0]  rt, rd, funct;
  logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic        pc_src, flush;
  logic [15:0] branch_target, mem_alu_result, mem_write_data;
  logic [2:0]  mem_write_reg;
  logic        mem_RegWrite, mem_MemtoReg, mem_MemRead, mem_MemWrite;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .pc_plus_two(pc_plus_two), .read_data_1(read_data_1), .read_data_2(read_data_2),
    .immediate(immediate), .rt(rt), .rd(rd), .funct(funct),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
    .pc_src(pc_src), .branch_target(branch_target), .flush(flush),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_write_reg(mem_write_reg), .mem_RegWrite(mem_RegWrite),
    .mem_MemtoReg(mem_MemtoReg), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slot kinds: cleared by reset, bubble (data don't-care), real instruction.
  localparam int K_ZERO = 0;
  localparam int K_BUB  = 1;
  localparam int K_INS  = 2;

  typedef struct {
    int kind;
    int pc2, r1, r2, imm, rt, rd, funct, aluop;
    bit reg_dst, alu_src, m2r, rw, mr, mw, br;
  } ex_rec_t;

  typedef struct {
    int kind;
    int res, wdata, wreg;
    bit rw, m2r, mr, mw;
  } mem_rec_t;

  ex_rec_t  m_ex;
  mem_rec_t m_mem;

  function automatic ex_rec_t empty_ex(input int kind);
    ex_rec_t e;
    e.kind = kind; e.pc2 = 0; e.r1 = 0; e.r2 = 0; e.imm = 0; e.rt = 0; e.rd = 0;
    e.funct = 0; e.aluop = 0; e.reg_dst = 0; e.alu_src = 0; e.m2r = 0; e.rw = 0;
    e.mr = 0; e.mw = 0; e.br = 0;
    return e;
  endfunction

  function automatic int to_signed16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int ref_alu(input ex_rec_t e);
    int a, b, r;
    a = e.r1;
    b = e.alu_src ? e.imm : e.r2;
    if (e.aluop == 1) r = a - b;
    else if (e.aluop == 2) begin
      case (e.funct)
        1: r = a - b;
        2: r = a & b;
        3: r = a | b;
        4: r = (to_signed16(a) < to_signed16(b)) ? 1 : 0;
        default: r = a + b;
      endcase
    end else r = a + b;
    return r & 65535;
  endfunction

  function automatic bit ref_taken(input ex_rec_t e);
    return (e.kind == K_INS) && e.br && (ref_alu(e) == 0);
  endfunction

  task automatic model_edge();
    bit taken;
    taken = ref_taken(m_ex);
    if (rst) begin
      m_ex  = empty_ex(K_ZERO);
      m_mem.kind = K_ZERO; m_mem.res = 0; m_mem.wdata = 0; m_mem.wreg = 0;
      m_mem.rw = 0; m_mem.m2r = 0; m_mem.mr = 0; m_mem.mw = 0;
      return;
    end
    m_mem.kind  = m_ex.kind;
    m_mem.res   = ref_alu(m_ex);
    m_mem.wdata = m_ex.r2;
    m_mem.wreg  = m_ex.reg_dst ? m_ex.rd : m_ex.rt;
    m_mem.rw    = m_ex.rw;
    m_mem.m2r   = m_ex.m2r;
    m_mem.mr    = m_ex.mr;
    m_mem.mw    = m_ex.mw;
    if (taken || stall) m_ex = empty_ex(K_BUB);
    else begin
      m_ex.kind = K_INS; m_ex.pc2 = pc_plus_two; m_ex.r1 = read_data_1; m_ex.r2 = read_data_2;
      m_ex.imm = immediate; m_ex.rt = rt; m_ex.rd = rd; m_ex.funct = funct; m_ex.aluop = ALUOp;
      m_ex.reg_dst = RegDst; m_ex.alu_src = ALUSrc; m_ex.m2r = MemtoReg; m_ex.rw = RegWrite;
      m_ex.mr = MemRead; m_ex.mw = MemWrite; m_ex.br = Branch;
    end
  endtask

  task automatic check_model();
    bit exp_taken;
    exp_taken = ref_taken(m_ex);
    check_val("pc_src", pc_src, exp_taken);
    check_val("flush", flush, exp_taken);
    if (m_ex.kind != K_BUB)
      check_val("branch_target", branch_target, (m_ex.pc2 + 2 * m_ex.imm) & 65535);
    check_val("mem_RegWrite", mem_RegWrite, m_mem.rw);
    check_val("mem_MemtoReg", mem_MemtoReg, m_mem.m2r);
    check_val("mem_MemRead", mem_MemRead, m_mem.mr);
    check_val("mem_MemWrite", mem_MemWrite, m_mem.mw);
    if (m_mem.kind != K_BUB) begin
      check_val("mem_alu_result", mem_alu_result, m_mem.res);
      check_val("mem_write_data", mem_write_data, m_mem.wdata);
      check_val("mem_write_reg", mem_write_reg, m_mem.wreg);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_idle();
    stall = 0; pc_plus_two = 0; read_data_1 = 0; read_data_2 = 0; immediate = 0;
    rt = 0; rd = 0; funct = 0; RegDst = 0; ALUSrc = 0; MemtoReg = 0; RegWrite = 0;
    MemRead = 0; MemWrite = 0; Branch = 0; ALUOp = 0;
  endtask

  task automatic rand_inputs();
    stall       = ($urandom_range(0, 7) == 0);
    pc_plus_two = 16'($urandom);
    read_data_1 = 16'($urandom);
    read_data_2 = ($urandom_range(0, 2) == 0) ? read_data_1 : 16'($urandom);
    immediate   = 16'($urandom);
    rt = 3'($urandom); rd = 3'($urandom); funct = 3'($urandom);
    RegDst = 1'($urandom); ALUSrc = ($urandom_range(0, 3) == 0);
    MemtoReg = 1'($urandom); RegWrite = 1'($urandom);
    MemRead = 1'($urandom); MemWrite = 1'($urandom);
    Branch = ($urandom_range(0, 3) == 0);
    ALUOp = 2'($urandom);
    rst = ($urandom_range(0, 49) == 0);
  endtask

  task automatic load_beq();
    set_idle();
    read_data_1 = 16'h0042; read_data_2 = 16'h0042; Branch = 1; ALUOp = 2'b01;
    pc_plus_two = 16'h0010; immediate = 16'h0004;
  endtask

  initial begin
    m_ex = empty_ex(K_ZERO);
    m_mem.kind = K_ZERO; m_mem.res = 0; m_mem.wdata = 0; m_mem.wreg = 0;
    m_mem.rw = 0; m_mem.m2r = 0; m_mem.mr = 0; m_mem.mw = 0;

    // Reset with every input nonzero
    rst = 1; stall = 1; pc_plus_two = 16'hFFFF; read_data_1 = 16'h1234; read_data_2 = 16'h1234;
    immediate = 16'h7777; rt = 3'd7; rd = 3'd6; funct = 3'd5; RegDst = 1; ALUSrc = 1;
    MemtoReg = 1; RegWrite = 1; MemRead = 1; MemWrite = 1; Branch = 1; ALUOp = 2'b11;
    step();
    step();
    check_val("rst_pc_src", pc_src, 0);
    check_val("rst_branch_target", branch_target, 0);
    check_val("rst_mem_result", mem_alu_result, 0);
    check_val("rst_mem_ctl", {mem_RegWrite, mem_MemtoReg, mem_MemRead, mem_MemWrite}, 0);
    rst = 0;

    // R-type add
    set_idle();
    read_data_1 = 16'h0005; read_data_2 = 16'h0003; ALUOp = 2'b10; funct = 3'b000;
    RegDst = 1; rd = 3'd5; RegWrite = 1;
    step(); set_idle(); step();
    check_val("add_result", mem_alu_result, 16'h0008);
    check_val("add_wreg", mem_write_reg, 5);
    check_val("add_regwrite", mem_RegWrite, 1);

    // Load address with negative offset
    ALUSrc = 1; ALUOp = 2'b00; read_data_1 = 16'h0100; immediate = 16'hFFFE; rt = 3'd2; MemRead = 1;
    step(); set_idle(); step();
    check_val("ld_result", mem_alu_result, 16'h00FE);
    check_val("ld_wreg", mem_write_reg, 2);
    check_val("ld_memread", mem_MemRead, 1);

    // Taken beq squashes the following instruction
    load_beq();
    step();
    check_val("beq_pc_src", pc_src, 1);
    check_val("beq_flush", flush, 1);
    check_val("beq_target", branch_target, 16'h0018);
    set_idle(); RegWrite = 1; RegDst = 1; rd = 3'd3;
    step(); set_idle(); step();
    check_val("beq_squash_regwrite", mem_RegWrite, 0);

    // slt signed and add wrap
    read_data_1 = 16'hFFFF; read_data_2 = 16'h0001; ALUOp = 2'b10; funct = 3'b100;
    step();
    set_idle(); read_data_1 = 16'h7FFF; read_data_2 = 16'h0001;
    step();
    check_val("slt_result", mem_alu_result, 16'h0001);
    set_idle(); step();
    check_val("wrap_result", mem_alu_result, 16'h8000);

    // Stall inserts one bubble
    set_idle(); RegWrite = 1; stall = 1;
    step(); set_idle(); step();
    check_val("stall_bubble", mem_RegWrite, 0);

    // Flush and stall together on the edge after a taken branch
    load_beq(); step();
    set_idle(); RegWrite = 1; stall = 1; step();
    set_idle(); step();
    check_val("flush_stall_bubble", mem_RegWrite, 0);

    // Reset while a branch is pending
    load_beq(); MemWrite = 1; step();
    set_idle(); RegWrite = 1; rst = 1; step();
    check_val("rst_branch_pc_src", pc_src, 0);
    check_val("rst_branch_mem", {mem_alu_result, mem_write_data, 1'b0, mem_write_reg,
                                 mem_RegWrite, mem_MemtoReg, mem_MemRead, mem_MemWrite}, 0);
    rst = 0;

    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port stall, input, 1, load a bubble into ID/EX instead of decode outputs.
REQ-004 SHALL have ports pc_plus_two, read_data_1, read_data_2, immediate; input; 16 each; from IF/ID and decode (immediate already sign-extended).
REQ-005 SHALL have ports rt, rd, funct; input; 3 each; instruction fields from IF/ID.
REQ-006 SHALL have ports RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch; input; 1 each; decode controls.
REQ-007 SHALL have port ALUOp, input, 2, from decode.
REQ-008 SHALL have ports pc_src (output, 1, take branch) and branch_target (output, 16, target PC); both feed fetch.
REQ-009 SHALL have port flush, output, 1, kill the IF/ID contents.
REQ-010 SHALL have ports mem_alu_result and mem_write_data; output; 16 each; EX/MEM data.
REQ-011 SHALL have port mem_write_reg, output, 3, destination register.
REQ-012 SHALL have ports mem_RegWrite, mem_MemtoReg, mem_MemRead, mem_MemWrite; output; 1 each; EX/MEM controls.

Function
REQ-013 SHALL hold two register stages: ID/EX, which captures all inputs, and EX/MEM, which captures the ALU result, store data, destination register and the four downstream controls.
REQ-014 SHALL use a single ID/EX load priority per edge: rst, then flush, then stall, then normal load; flush or stall loads a bubble with every control bit 0.
REQ-015 SHALL select ALU operand B as the ID/EX immediate when ALUSrc=1, else ID/EX read_data_2.
REQ-016 SHALL decode ALUOp: 00 = add; 01 = sub; 10 = by funct; 11 = add.
REQ-017 SHALL decode funct: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 0x0001/0x0000), all other codes add.
REQ-018 SHALL wrap all arithmetic modulo 2^16 and raise no overflow indication.
REQ-019 SHALL select mem_write_reg as ID/EX rd when RegDst=1, else ID/EX rt.
REQ-020 SHALL drive mem_write_data from ID/EX read_data_2, unaffected by ALUSrc.
REQ-021 SHALL compute branch_target = ID/EX pc_plus_two + (ID/EX immediate << 1), truncated to 16 bits, combinationally and every cycle.
REQ-022 SHALL assert pc_src combinationally when ID/EX Branch=1 and the ALU result is 0x0000.
REQ-023 SHALL drive flush equal to pc_src.
REQ-024 SHALL give 2-cycle latency: inputs captured at edge k appear on the mem_* outputs after edge k+1, and the pc_src decision for those inputs is valid between edges k and k+1.
REQ-025 SHALL let a taken branch propagate its own Branch-free controls into EX/MEM, and SHALL turn the instruction loaded on the same edge into a bubble.
REQ-026 SHALL treat flush and stall asserted together as a single bubble.

Reset
REQ-027 SHALL clear both ID/EX and EX/MEM to zero on a rising edge with rst=1, so all mem_* outputs are 0 and pc_src, flush and branch_target are 0 after that edge.
REQ-028 SHALL, when rst is asserted mid-operation, discard in-flight instructions without side effects; the first instruction after rst falls is treated as new.

Structure
REQ-029 SHALL place the ALUOp codes, funct codes, data width (16) and register-index width (3) in a shared package used by fetch and decode.
REQ-030 SHALL implement the ALU as one combinational sub-module, alu16, with inputs a, b and op and output result.

Verification
REQ-031 Reset: rst=1 with all inputs nonzero for 1 edge -> every output is 0.
REQ-032 R-type add: read1=0x0005, read2=0x0003, ALUOp=10, funct=000, RegDst=1, rd=5, RegWrite=1 -> after 2 edges mem_alu_result=0x0008, mem_write_reg=5, mem_RegWrite=1.
REQ-033 Load: ALUSrc=1, ALUOp=00, read1=0x0100, imm=0xFFFE, rt=2, MemRead=1 -> mem_alu_result=0x00FE, mem_write_reg=2, mem_MemRead=1.
REQ-034 Taken beq: read1=read2=0x0042, Branch=1, ALUOp=01, pc_plus_two=0x0010, imm=0x0004 -> pc_src=1, flush=1, branch_target=0x0018; the following instruction (RegWrite=1) reaches EX/MEM with mem_RegWrite=0.
REQ-035 slt signed: read1=0xFFFF, read2=0x0001, funct=100 -> mem_alu_result=0x0001; wrap case 0x7FFF+0x0001 -> 0x8000.
REQ-036 Stall and rst together: stall=1 for 1 edge -> one bubble; rst=1 during a pending branch -> pc_src=0 and all EX/MEM outputs 0 after that edge.
